// File: rtl/vga_timing_pkg.sv
// Raster timing modes, sync bundle and sizing helpers
// shared by the vga_timing_gen slice.
package vga_timing_pkg;

  typedef enum logic [0:0] {
    MODE_640X480_60,
    MODE_800X600_72
  } vga_mode_e;

  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FRONT  = 16;
  localparam int M640_H_SYNC   = 96;
  localparam int M640_H_BACK   = 48;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FRONT  = 10;
  localparam int M640_V_SYNC   = 2;
  localparam int M640_V_BACK   = 33;
  localparam bit M640_HS_POL   = 1'b0;
  localparam bit M640_VS_POL   = 1'b0;

  localparam int M800_H_ACTIVE = 800;
  localparam int M800_H_FRONT  = 56;
  localparam int M800_H_SYNC   = 120;
  localparam int M800_H_BACK   = 64;
  localparam int M800_V_ACTIVE = 600;
  localparam int M800_V_FRONT  = 37;
  localparam int M800_V_SYNC   = 6;
  localparam int M800_V_BACK   = 23;
  localparam bit M800_HS_POL   = 1'b1;
  localparam bit M800_VS_POL   = 1'b1;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic line_start;
    logic frame_start;
  } vga_sync_t;

  function automatic int h_total(
    input int act,
    input int front,
    input int sync,
    input int back
  );
    return act + front + sync + back;
  endfunction

  function automatic int v_total(
    input int act,
    input int front,
    input int sync,
    input int back
  );
    return act + front + sync + back;
  endfunction

  // Bits needed to hold total-1
  function automatic int min_cnt_w(
    input int total
  );
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis counter: 0..LEN-1 on i_Inc,
// o_Wrap flags the increment that returns to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int LEN = 800,
  parameter int W   = 10
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Inc,
  output logic [W-1:0] o_Count,
  output logic         o_Wrap
);

  localparam logic [W-1:0] LAST = W'(LEN - 1);

  logic at_last;

  assign at_last = (o_Count == LAST);
  assign o_Wrap  = i_Inc & at_last;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Count <= '0;
    end else if (i_Inc) begin
      o_Count <= at_last ? '0 : o_Count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster sync generator; optional pixel
// clock-enable via VGA_TIMING_PIXEL_CE_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = M640_H_ACTIVE,
  parameter int H_FRONT  = M640_H_FRONT,
  parameter int H_SYNC   = M640_H_SYNC,
  parameter int H_BACK   = M640_H_BACK,
  parameter int V_ACTIVE = M640_V_ACTIVE,
  parameter int V_FRONT  = M640_V_FRONT,
  parameter int V_SYNC   = M640_V_SYNC,
  parameter int V_BACK   = M640_V_BACK,
  parameter bit HS_POL   = M640_HS_POL,
  parameter bit VS_POL   = M640_VS_POL,
  parameter int CNT_W    = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
`ifdef VGA_TIMING_PIXEL_CE_EN
  input  logic             i_Pix_CE,
`endif
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic             o_Line_Start,
  output logic             o_Frame_Start,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count
);

  localparam int H_TOTAL =
    h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (H_ACTIVE < 1 || H_FRONT < 1 ||
      H_SYNC < 1 || H_BACK < 1) begin : g_bad_h
    $error("vga_timing_gen: H_ params must be >= 1");
  end

  if (V_ACTIVE < 1 || V_FRONT < 1 ||
      V_SYNC < 1 || V_BACK < 1) begin : g_bad_v
    $error("vga_timing_gen: V_ params must be >= 1");
  end

  if (CNT_W < min_cnt_w(H_TOTAL) ||
      CNT_W < min_cnt_w(V_TOTAL)) begin : g_bad_w
    $error("vga_timing_gen: CNT_W too small");
  end

  localparam logic [CNT_W-1:0] H_ACT_END =
    CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG =
    CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END =
    CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG =
    CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam vga_sync_t SYNC_RST = '{
    hsync:       ~HS_POL,
    vsync:       ~VS_POL,
    active:      1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic             ce;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             in_hs;
  logic             in_vs;
  vga_sync_t        sync_d;
  vga_sync_t        sync_q;

`ifdef VGA_TIMING_PIXEL_CE_EN
  assign ce = i_Pix_CE;
`else
  assign ce = 1'b1;
`endif

  vga_axis_counter #(
    .LEN (H_TOTAL),
    .W   (CNT_W)
  ) u_h_cnt (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Inc   (ce),
    .o_Count (h_cnt),
    .o_Wrap  (h_wrap)
  );

  // Row advances only on the column wrap, so sync
  // and active rows change at line boundaries.
  vga_axis_counter #(
    .LEN (V_TOTAL),
    .W   (CNT_W)
  ) u_v_cnt (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Inc   (h_wrap),
    .o_Count (v_cnt),
    .o_Wrap  (v_wrap_unused)
  );

  assign in_hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign in_vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  always_comb begin
    sync_d             = SYNC_RST;
    sync_d.hsync       = in_hs ? HS_POL : ~HS_POL;
    sync_d.vsync       = in_vs ? VS_POL : ~VS_POL;
    sync_d.active      = (h_cnt < H_ACT_END) &&
                         (v_cnt < V_ACT_END);
    sync_d.line_start  = (h_cnt == '0);
    sync_d.frame_start = (h_cnt == '0) &&
                         (v_cnt == '0);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_q      <= SYNC_RST;
      o_Col_Count <= '0;
      o_Row_Count <= '0;
    end else if (ce) begin
      sync_q      <= sync_d;
      o_Col_Count <= h_cnt;
      o_Row_Count <= v_cnt;
    end
  end

  assign o_HSync       = sync_q.hsync;
  assign o_VSync       = sync_q.vsync;
  assign o_Active      = sync_q.active;
  assign o_Line_Start  = sync_q.line_start;
  assign o_Frame_Start = sync_q.frame_start;

endmodule
